// File: rtl/dl_slp_adc_mc_if.sv
// rtl/dl_slp_adc_mc_if.sv - channel select, start handshake and result bus of the dual-slope ADC model
interface dl_slp_adc_mc_if #(
   parameter int NCH   = 4,
   parameter int NBITS = 8
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   real              ana_in [NCH];
   logic [CHW-1:0]   ch_sel;
   logic             start;
   logic             busy;
   logic             done;
   logic [NBITS-1:0] code;
   logic             ovf;
   logic             cmp_out;

   modport master (
      output ana_in, ch_sel, start,
      input  busy, done, code, ovf, cmp_out
   );

   modport slave (
      input  ana_in, ch_sel, start,
      output busy, done, code, ovf, cmp_out
   );
endinterface

// File: rtl/dl_slp_adc_mc.sv
// rtl/dl_slp_adc_mc.sv - multi-channel dual-slope ADC behavioural model; optional auto-zero via DL_SLP_AUTOZERO_EN
module dl_slp_adc_mc #(
   parameter int  NCH    = 4,
   parameter int  NBITS  = 8,
   parameter real VREF   = 1.0,
   parameter int  AZ_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   dl_slp_adc_mc_if.slave       bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AZW = $clog2(AZ_CYC + 1);
   // one counter serves auto-zero, run-up and rundown, so size it for the longest use
   localparam int CW  = (NBITS > AZW) ? NBITS : AZW;
   localparam logic [CW-1:0] RUN_LAST = CW'(2**NBITS - 1);
`ifdef DL_SLP_AUTOZERO_EN
   localparam logic [CW-1:0] AZ_LAST  = CW'(AZ_CYC - 1);
`endif

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
`ifdef DL_SLP_AUTOZERO_EN
      AZERO   = 3'd1,
`endif
      RUNUP   = 3'd2,
      RUNDOWN = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t           state;
   real              integ;
   real              ana_sel;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_inc;
   logic [CHW-1:0]   ch_q;
   logic             busy_q;
   logic             done_q;
   logic [NBITS-1:0] code_q;
   logic             ovf_q;

   assign cnt_inc = cnt + CW'(1);

   // live voltage of the latched channel; out-of-range indices read as 0 V
   always_comb begin
      ana_sel = 0.0;
      for (int i = 0; i < NCH; i++) begin
         if (ch_q == CHW'(i)) ana_sel = bus.ana_in[i];
      end
   end

   // conversion sequencer: integrate input, de-integrate reference, report the count
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         integ  <= 0.0;
         cnt    <= '0;
         ch_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         code_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  ch_q   <= bus.ch_sel;
                  integ  <= 0.0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
`ifdef DL_SLP_AUTOZERO_EN
                  state  <= AZERO;
`else
                  state  <= RUNUP;
`endif
               end
            end
`ifdef DL_SLP_AUTOZERO_EN
            AZERO: begin
               integ <= 0.0;
               if (cnt == AZ_LAST) begin
                  cnt   <= '0;
                  state <= RUNUP;
               end else begin
                  cnt <= cnt_inc;
               end
            end
`endif
            RUNUP: begin
               integ <= integ + ana_sel;
               if (cnt == RUN_LAST) begin
                  cnt <= '0;
                  // nothing to de-integrate for zero or negative input
                  if (integ + ana_sel <= 0.0) begin
                     code_q <= '0;
                     ovf_q  <= 1'b0;
                     state  <= DONE;
                  end else begin
                     state  <= RUNDOWN;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RUNDOWN: begin
               integ <= integ - VREF;
               cnt   <= cnt_inc;
               if (integ - VREF <= 0.0) begin
                  code_q <= cnt_inc[NBITS-1:0];
                  ovf_q  <= 1'b0;
                  state  <= DONE;
               end else if (cnt_inc == RUN_LAST) begin
                  code_q <= '1;
                  ovf_q  <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.code    = code_q;
   assign bus.ovf     = ovf_q;
   assign bus.cmp_out = (integ > 0.0);

endmodule

// File: tb/tb_dl_slp_adc_mc.sv
// tb/tb_dl_slp_adc_mc.sv - directed bench for dl_slp_adc_mc (NCH=4, NBITS=4, VREF=1.0)
module tb_dl_slp_adc_mc;
`ifdef DL_SLP_AUTOZERO_EN
   localparam int AZ = 4;
`else
   localparam int AZ = 0;
`endif

   logic clk;
   logic rstn;
   int   n_cmp;
   int   n_err;

   dl_slp_adc_mc_if #(.NCH(4), .NBITS(4)) bus ();

   dl_slp_adc_mc #(.NCH(4), .NBITS(4), .VREF(1.0), .AZ_CYC(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one conversion: start on channel ch, optional extra start pulse sampled at edge inj_k
   task automatic run_conv(input int ch, input int inj_k, input int inj_ch,
                           output int lat, output int ndone, output logic busy0,
                           output logic cmp_mid, output logic busy_end);
      @(negedge clk);
      bus.ch_sel = 2'(ch);
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      busy0     = bus.busy;
      lat       = -1;
      ndone     = 0;
      cmp_mid   = 1'bx;
      for (int k = 1; k <= 60; k++) begin
         if (k == inj_k) begin
            bus.start  = 1'b1;
            bus.ch_sel = 2'(inj_ch);
         end
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (k == 8 + AZ) cmp_mid = bus.cmp_out;
         if (bus.done === 1'b1) begin
            ndone++;
            if (lat < 0) lat = k;
         end
      end
      busy_end = bus.busy;
   endtask

   task automatic test_reset();
      rstn      = 1'b0;
      bus.start = 1'b0;
      bus.ch_sel = '0;
      for (int i = 0; i < 4; i++) bus.ana_in[i] = 0.0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.code, bus.ovf, bus.cmp_out} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b done=%b code=%0d ovf=%b cmp=%b, need all 0",
                  bus.busy, bus.done, bus.code, bus.ovf, bus.cmp_out);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_half_scale();
      int lat, nd; logic b0, cm, be;
      bus.ana_in[2] = 0.5;
      bus.ana_in[3] = 0.75;
      run_conv(2, -1, 0, lat, nd, b0, cm, be);
      n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL half_busy_rise: got %b need 1", b0); end
      n_cmp++; if (cm !== 1'b1) begin n_err++; $display("FAIL half_cmp_mid: got %b need 1", cm); end
      n_cmp++; if (lat !== 25 + AZ) begin n_err++; $display("FAIL half_latency: got %0d need %0d", lat, 25 + AZ); end
      n_cmp++; if (bus.code !== 4'd8) begin n_err++; $display("FAIL half_code: got %0d need 8", bus.code); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL half_ovf: got %b need 0", bus.ovf); end
      n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL half_done_count: got %0d need 1", nd); end
   endtask

   task automatic test_negative();
      int lat, nd; logic b0, cm, be;
      bus.ana_in[0] = -0.3;
      run_conv(0, -1, 0, lat, nd, b0, cm, be);
      n_cmp++; if (cm !== 1'b0) begin n_err++; $display("FAIL neg_cmp_mid: got %b need 0", cm); end
      n_cmp++; if (lat !== 17 + AZ) begin n_err++; $display("FAIL neg_latency: got %0d need %0d", lat, 17 + AZ); end
      n_cmp++; if (bus.code !== 4'd0) begin n_err++; $display("FAIL neg_code: got %0d need 0", bus.code); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL neg_ovf: got %b need 0", bus.ovf); end
   endtask

   task automatic test_overflow();
      int lat, nd; logic b0, cm, be;
      bus.ana_in[1] = 1.2;
      run_conv(1, -1, 0, lat, nd, b0, cm, be);
      n_cmp++; if (lat !== 32 + AZ) begin n_err++; $display("FAIL ovf_latency: got %0d need %0d", lat, 32 + AZ); end
      n_cmp++; if (bus.code !== 4'd15) begin n_err++; $display("FAIL ovf_code: got %0d need 15", bus.code); end
      n_cmp++; if (bus.ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b need 1", bus.ovf); end
   endtask

   task automatic test_start_ignored();
      int lat, nd; logic b0, cm, be;
      run_conv(2, 5 + AZ, 3, lat, nd, b0, cm, be);
      n_cmp++; if (bus.code !== 4'd8) begin n_err++; $display("FAIL busy_start_code: got %0d need 8", bus.code); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL busy_start_ovf: got %b need 0", bus.ovf); end
      n_cmp++; if (lat !== 25 + AZ) begin n_err++; $display("FAIL busy_start_latency: got %0d need %0d", lat, 25 + AZ); end
      n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d need 1", nd); end
   endtask

   task automatic test_start_in_done();
      int lat, nd; logic b0, cm, be;
      run_conv(2, 25 + AZ, 3, lat, nd, b0, cm, be);
      n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL done_start_done_count: got %0d need 1", nd); end
      n_cmp++; if (be !== 1'b0) begin n_err++; $display("FAIL done_start_busy_after: got %b need 0", be); end
      n_cmp++; if (bus.code !== 4'd8) begin n_err++; $display("FAIL done_start_code: got %0d need 8", bus.code); end
   endtask

   task automatic test_reset_mid();
      int lat, nd, nd_rst; logic b0, cm, be;
      @(negedge clk);
      bus.ch_sel = 2'd2;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (19 + AZ) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.code, bus.ovf, bus.cmp_out} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b code=%0d ovf=%b cmp=%b, need all 0",
                  bus.busy, bus.done, bus.code, bus.ovf, bus.cmp_out);
      end
      nd_rst = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) nd_rst++;
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) nd_rst++;
      end
      n_cmp++; if (nd_rst !== 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d pulses need 0", nd_rst); end
      bus.ana_in[1] = 0.25;
      run_conv(1, -1, 0, lat, nd, b0, cm, be);
      n_cmp++; if (bus.code !== 4'd4) begin n_err++; $display("FAIL reset_mid_new_code: got %0d need 4", bus.code); end
      n_cmp++; if (lat !== 21 + AZ) begin n_err++; $display("FAIL reset_mid_new_latency: got %0d need %0d", lat, 21 + AZ); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_half_scale();
      test_negative();
      test_overflow();
      test_start_ignored();
      test_start_in_done();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
